epb_wb_bridge: RTL and testbench

Converts asynchronous EPB bus cycles into single-beat Wishbone classic transactions on the fabric clock.
- Upstream: the EPB pad-buffer stage. The bridge consumes its de-padded control, address and input data, and returns output data, the data tristate control, and rdy/rdy_oe.
- Downstream: the Wishbone interconnect to the fabric register/memory slaves.
- Includes a timeout counter so a dead slave cannot hang the processor.

---
 rtl/epb_wb_bridge_pkg.sv | 26 ++
 rtl/epb_wb_bridge_if.sv | 48 ++++
 rtl/epb_wb_bridge_sync.sv | 26 ++
 rtl/epb_wb_bridge.sv | 121 ++++++++++++
 tb/tb_epb_wb_bridge.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/epb_wb_bridge_pkg.sv
// Shared types, widths and address mapping for the EPB-to-Wishbone bridge.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package epb_wb_pkg;

    localparam int EPB_ADDR_W = 23;
    localparam int EPB_GP_W   = 6;
    localparam int EPB_DATA_W = 16;
    localparam int WB_ADR_W   = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WB   = 2'd1,
        ST_RDY  = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    // EPB word address plus GP bits, turned into a Wishbone byte address.
    function automatic logic [WB_ADR_W-1:0] epb_byte_adr(
        input logic [EPB_GP_W-1:0]   gp,
        input logic [EPB_ADDR_W-1:0] addr
    );
        return {2'b00, gp, addr, 1'b0};
    endfunction

endpackage

// File: rtl/epb_wb_bridge_if.sv
// EPB pad-side and Wishbone master-side signal bundle for the bridge.
// Latency: n/a (wiring only).
// Backpressure: Wishbone slave stalls via wb_ack_i; EPB host waits on epb_rdy.
interface epb_wb_bridge_if;
    import epb_wb_pkg::*;

    logic                  epb_cs_n;
    logic                  epb_oe_n;
    logic                  epb_r_w_n;
    logic [1:0]            epb_be_n;
    logic [EPB_ADDR_W-1:0] epb_addr;
    logic [EPB_GP_W-1:0]   epb_addr_gp;
    logic [EPB_DATA_W-1:0] epb_data_in;
    logic [EPB_DATA_W-1:0] epb_data_out;
    logic                  epb_data_oe_n;
    logic                  epb_rdy;
    logic                  epb_rdy_oe;

    logic                  wb_cyc_o;
    logic                  wb_stb_o;
    logic                  wb_we_o;
    logic [WB_ADR_W-1:0]   wb_adr_o;
    logic [1:0]            wb_sel_o;
    logic [EPB_DATA_W-1:0] wb_dat_o;
    logic [EPB_DATA_W-1:0] wb_dat_i;
    logic                  wb_ack_i;

    logic [15:0]           timeout_cnt;

    // Bridge view: it is the Wishbone master.
    modport master (
        input  epb_cs_n, epb_oe_n, epb_r_w_n, epb_be_n, epb_addr, epb_addr_gp,
               epb_data_in, wb_dat_i, wb_ack_i,
        output epb_data_out, epb_data_oe_n, epb_rdy, epb_rdy_oe,
               wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
               timeout_cnt
    );

    // Environment view: EPB pads plus the Wishbone slave.
    modport slave (
        output epb_cs_n, epb_oe_n, epb_r_w_n, epb_be_n, epb_addr, epb_addr_gp,
               epb_data_in, wb_dat_i, wb_ack_i,
        input  epb_data_out, epb_data_oe_n, epb_rdy, epb_rdy_oe,
               wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
               timeout_cnt
    );

endinterface

// File: rtl/epb_wb_bridge_sync.sv
// Multi-flop synchronizer for one asynchronous control bit, resets to 1.
// Latency: STAGES clocks.
// Backpressure: none.
module epb_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    // Shift the asynchronous input through the chain; reset parks it inactive (high).
    always_ff @(posedge clk) begin
        if (rst) begin
            ff <= '1;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/epb_wb_bridge.sv
// Turns one asynchronous EPB cycle into one single-beat Wishbone classic transaction.
// Latency: SYNC_STAGES+1 clocks from cs_n fall to cyc; rdy one clock after ack/timeout.
// Backpressure: holds cyc/stb until wb_ack_i or TIMEOUT cycles, whichever comes first.
module epb_wb_bridge
    import epb_wb_pkg::*;
#(
    parameter int                    SYNC_STAGES  = 2,
    parameter int                    TIMEOUT      = 1024,
    parameter logic [EPB_DATA_W-1:0] TIMEOUT_DATA = 16'hDEAD
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    epb_wb_bridge_if.master  bus
);

    localparam int CNT_W = $clog2(TIMEOUT);

    logic cs_s, oe_s, rw_s;
    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] flush;      // fills with ones once the synchronizers carry real samples
    logic                   armed;      // cs_s seen high while idle/holding
    logic                   aborted;    // host dropped cs during the Wishbone phase
    logic [CNT_W-1:0]       wb_cnt;

    logic                  we_q;
    logic [WB_ADR_W-1:0]   adr_q;
    logic [1:0]            sel_q;
    logic [EPB_DATA_W-1:0] wdat_q;
    logic [EPB_DATA_W-1:0] rdat_q;
    logic [15:0]           tmo_cnt_q;

    logic start, ack, tmo_hit;

    epb_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_cs (
        .clk(wb_clk_i), .rst(wb_rst_i), .d(bus.epb_cs_n), .q(cs_s));
    epb_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_oe (
        .clk(wb_clk_i), .rst(wb_rst_i), .d(bus.epb_oe_n), .q(oe_s));
    epb_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_rw (
        .clk(wb_clk_i), .rst(wb_rst_i), .d(bus.epb_r_w_n), .q(rw_s));

    assign start   = (state == ST_IDLE) && armed && !cs_s;
    assign tmo_hit = (wb_cnt == CNT_W'(TIMEOUT - 1));
    assign ack     = (state == ST_WB) && bus.wb_ack_i;

    // State register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: an aborted cycle finishes on the bus but skips the rdy pulse.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_WB;
            ST_WB:   if (bus.wb_ack_i || tmo_hit) state_nxt = (aborted || cs_s) ? ST_IDLE : ST_RDY;
            ST_RDY:  state_nxt = ST_HOLD;
            ST_HOLD: if (cs_s) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Capture the request at cycle start, run the timeout, latch read data on completion.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            flush     <= '0;
            armed     <= 1'b0;
            aborted   <= 1'b0;
            wb_cnt    <= '0;
            we_q      <= 1'b0;
            adr_q     <= '0;
            sel_q     <= '0;
            wdat_q    <= '0;
            rdat_q    <= '0;
            tmo_cnt_q <= '0;
        end else begin
            flush <= {flush[SYNC_STAGES-2:0], 1'b1};
            if (start) begin
                armed <= 1'b0;
            end else if ((state == ST_IDLE || state == ST_HOLD) && flush[SYNC_STAGES-1] && cs_s) begin
                armed <= 1'b1;
            end
            if (start) begin
                adr_q   <= epb_byte_adr(bus.epb_addr_gp, bus.epb_addr);
                sel_q   <= ~bus.epb_be_n;
                wdat_q  <= bus.epb_data_in;
                we_q    <= ~rw_s;
                wb_cnt  <= '0;
                aborted <= 1'b0;
            end
            if (state == ST_WB) begin
                wb_cnt <= wb_cnt + CNT_W'(1);
                if (cs_s) aborted <= 1'b1;
                if (ack) begin
                    if (!we_q) rdat_q <= bus.wb_dat_i;
                end else if (tmo_hit) begin
                    if (!we_q) rdat_q <= TIMEOUT_DATA;
                    if (tmo_cnt_q != 16'hFFFF) tmo_cnt_q <= tmo_cnt_q + 16'd1;
                end
            end
        end
    end

    assign bus.wb_cyc_o      = (state == ST_WB);
    assign bus.wb_stb_o      = (state == ST_WB);
    assign bus.wb_we_o       = we_q;
    assign bus.wb_adr_o      = adr_q;
    assign bus.wb_sel_o      = sel_q;
    assign bus.wb_dat_o      = wdat_q;
    assign bus.epb_data_out  = rdat_q;
    assign bus.epb_rdy       = (state == ST_RDY);
    assign bus.epb_rdy_oe    = (state != ST_IDLE);
    // Drive the pads only once read data is valid and the host is asking for it.
    assign bus.epb_data_oe_n = !((state == ST_RDY || state == ST_HOLD) && !we_q && !oe_s);
    assign bus.timeout_cnt   = tmo_cnt_q;

endmodule

// File: tb/tb_epb_wb_bridge.sv
// Self-checking bench for epb_wb_bridge with a per-transaction scoreboard.
// Latency: n/a.
// Backpressure: bench plays the Wishbone slave with a programmable ack delay.
module tb_epb_wb_bridge;

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [1:0]  sel;
        logic [15:0] wdat;
        logic [15:0] rdat;
        logic [7:0]  cyc_len;
        logic [3:0]  rdy_cnt;
        logic [3:0]  oe_low;
        logic [3:0]  idle_lat;
        logic        hung;
    } txn_t;

    localparam logic [87:0] RST_VEC = {3'b000, 32'h0, 2'b00, 16'h0, 16'h0, 1'b1, 2'b00, 16'h0};

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    txn_t exp_q[$];
    txn_t obs_q[$];

    epb_wb_bridge_if bus();

    epb_wb_bridge #(
        .SYNC_STAGES (2),
        .TIMEOUT     (16),
        .TIMEOUT_DATA(16'hDEAD)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .bus     (bus.master)
    );

    wire [87:0] out_vec = {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_adr_o, bus.wb_sel_o,
                           bus.wb_dat_o, bus.epb_data_out, bus.epb_data_oe_n, bus.epb_rdy,
                           bus.epb_rdy_oe, bus.timeout_cnt};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic txn_t mk(input logic we, input logic [31:0] adr, input logic [1:0] sel,
                                input logic [15:0] wdat, input logic [15:0] rdat,
                                input int cyc_len, input int rdy_cnt, input int oe_low,
                                input int idle_lat);
        txn_t t;
        t.we = we; t.adr = adr; t.sel = sel; t.wdat = wdat; t.rdat = rdat;
        t.cyc_len = 8'(cyc_len); t.rdy_cnt = 4'(rdy_cnt); t.oe_low = 4'(oe_low);
        t.idle_lat = 4'(idle_lat); t.hung = 1'b0;
        return t;
    endfunction

    // Drive one EPB cycle, play the Wishbone slave, record what the DUT did.
    task automatic run_cycle(input bit rd, input logic [22:0] a, input logic [5:0] gp,
                             input logic [1:0] be_n, input logic [15:0] wd, input int ack_at,
                             input logic [15:0] rd_dat, input int abort_at);
        txn_t o;
        int   cl;
        int   hold;
        bit   done;
        o = '0; cl = 0; hold = 0; done = 1'b0;
        @(negedge clk);
        bus.epb_addr = a; bus.epb_addr_gp = gp; bus.epb_be_n = be_n; bus.epb_data_in = wd;
        bus.epb_r_w_n = rd; bus.epb_oe_n = !rd; bus.wb_dat_i = rd_dat; bus.epb_cs_n = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (bus.wb_cyc_o) begin
                cl++;
                if (cl == 1) begin
                    o.we = bus.wb_we_o; o.adr = bus.wb_adr_o;
                    o.sel = bus.wb_sel_o; o.wdat = bus.wb_dat_o;
                end
            end
            if (bus.epb_rdy) o.rdy_cnt++;
            if (!bus.epb_cs_n && !bus.epb_data_oe_n) o.oe_low++;
            bus.wb_ack_i = bus.wb_cyc_o && (cl == ack_at);
            if (abort_at != 0 && bus.wb_cyc_o && cl == abort_at) begin
                bus.epb_cs_n = 1'b1; bus.epb_oe_n = 1'b1;
            end
            if (o.rdy_cnt != 0) hold++;
            if (hold == 3) done = 1'b1;
            if (bus.epb_cs_n && cl > 0 && !bus.wb_cyc_o && !bus.epb_rdy_oe) done = 1'b1;
        end
        o.hung = !done;
        bus.wb_ack_i = 1'b0;
        if (!bus.epb_cs_n) begin
            bus.epb_cs_n = 1'b1; bus.epb_oe_n = 1'b1;
            for (int k = 1; k <= 15; k++) begin
                @(negedge clk);
                if (!bus.epb_rdy_oe) begin o.idle_lat = 4'(k); break; end
            end
        end else begin
            repeat (4) begin
                @(negedge clk);
                if (bus.epb_rdy) o.rdy_cnt++;
            end
        end
        o.cyc_len = 8'(cl);
        o.rdat = rd ? bus.epb_data_out : 16'h0;
        obs_q.push_back(o);
    endtask

    task automatic test_reset();
        int busy;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (out_vec !== RST_VEC) $display("FAIL reset_outputs got %h want %h", out_vec, RST_VEC);
        else n_pass++;
        rst = 1'b0;
        bus.wb_ack_i = 1'b1;
        busy = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.wb_cyc_o || bus.epb_rdy || bus.epb_rdy_oe) busy++;
        end
        bus.wb_ack_i = 1'b0;
        n_checks++;
        if (busy !== 0) $display("FAIL idle_ack_ignored got %0d busy cycles want 0", busy);
        else n_pass++;
    endtask

    task automatic test_write();
        txn_t e, o;
        exp_q.push_back(mk(1'b1, 32'h00000020, 2'b11, 16'h1234, 16'h0, 3, 1, 0, 3));
        run_cycle(1'b0, 23'h000010, 6'h00, 2'b00, 16'h1234, 3, 16'h0000, 0);
        e = exp_q.pop_front(); o = obs_q.pop_front();
        n_checks++;
        if (o !== e) $display("FAIL write got %h want %h", o, e);
        else n_pass++;
    endtask

    task automatic test_read();
        txn_t e, o;
        exp_q.push_back(mk(1'b0, 32'h1555554A, 2'b01, 16'h0F0F, 16'hBEEF, 1, 1, 3, 3));
        run_cycle(1'b1, 23'h2AAAA5, 6'h15, 2'b10, 16'h0F0F, 1, 16'hBEEF, 0);
        e = exp_q.pop_front(); o = obs_q.pop_front();
        n_checks++;
        if (o !== e) $display("FAIL read got %h want %h", o, e);
        else n_pass++;
    endtask

    task automatic test_timeout();
        txn_t e, o;
        exp_q.push_back(mk(1'b0, 32'h3FFFFFFE, 2'b10, 16'h0000, 16'hDEAD, 16, 1, 3, 3));
        run_cycle(1'b1, 23'h7FFFFF, 6'h3F, 2'b01, 16'h0000, 0, 16'h7777, 0);
        e = exp_q.pop_front(); o = obs_q.pop_front();
        n_checks++;
        if (o !== e) $display("FAIL timeout_txn got %h want %h", o, e);
        else n_pass++;
        n_checks++;
        if (bus.timeout_cnt !== 16'd1) $display("FAIL timeout_cnt got %0d want 1", bus.timeout_cnt);
        else n_pass++;
    endtask

    task automatic test_ack_vs_timeout();
        txn_t e, o;
        exp_q.push_back(mk(1'b0, 32'h00000002, 2'b11, 16'h0001, 16'h5A5A, 16, 1, 3, 3));
        run_cycle(1'b1, 23'h000001, 6'h00, 2'b00, 16'h0001, 16, 16'h5A5A, 0);
        e = exp_q.pop_front(); o = obs_q.pop_front();
        n_checks++;
        if (o !== e) $display("FAIL ack_vs_timeout got %h want %h", o, e);
        else n_pass++;
        n_checks++;
        if (bus.timeout_cnt !== 16'd1) $display("FAIL ack_wins_cnt got %0d want 1", bus.timeout_cnt);
        else n_pass++;
    endtask

    task automatic test_abort();
        txn_t e, o;
        exp_q.push_back(mk(1'b1, 32'h0000000A, 2'b11, 16'hAAAA, 16'h0, 4, 0, 0, 0));
        exp_q.push_back(mk(1'b1, 32'h0000000C, 2'b11, 16'h5555, 16'h0, 2, 1, 0, 3));
        run_cycle(1'b0, 23'h000005, 6'h00, 2'b00, 16'hAAAA, 4, 16'h0000, 1);
        run_cycle(1'b0, 23'h000006, 6'h00, 2'b00, 16'h5555, 2, 16'h0000, 0);
        e = exp_q.pop_front(); o = obs_q.pop_front();
        n_checks++;
        if (o !== e) $display("FAIL abort got %h want %h", o, e);
        else n_pass++;
        e = exp_q.pop_front(); o = obs_q.pop_front();
        n_checks++;
        if (o !== e) $display("FAIL after_abort got %h want %h", o, e);
        else n_pass++;
    endtask

    task automatic test_reset_mid_wb();
        txn_t e, o;
        int   cyc_seen;
        @(negedge clk);
        bus.epb_addr = 23'h000003; bus.epb_addr_gp = 6'h00; bus.epb_be_n = 2'b00;
        bus.epb_r_w_n = 1'b1; bus.epb_oe_n = 1'b0; bus.wb_ack_i = 1'b0; bus.epb_cs_n = 1'b0;
        for (int i = 0; i < 20 && !bus.wb_cyc_o; i++) @(negedge clk);
        n_checks++;
        if (bus.wb_cyc_o !== 1'b1) $display("FAIL mid_wb_start got cyc %b want 1", bus.wb_cyc_o);
        else n_pass++;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (out_vec !== RST_VEC) $display("FAIL mid_reset_outputs got %h want %h", out_vec, RST_VEC);
        else n_pass++;
        cyc_seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.wb_cyc_o || bus.epb_rdy_oe) cyc_seen++;
        end
        n_checks++;
        if (cyc_seen !== 0) $display("FAIL cs_low_after_reset got %0d busy cycles want 0", cyc_seen);
        else n_pass++;
        bus.epb_cs_n = 1'b1; bus.epb_oe_n = 1'b1;
        repeat (4) @(negedge clk);
        exp_q.push_back(mk(1'b1, 32'h0100000E, 2'b11, 16'hC0DE, 16'h0, 1, 1, 0, 3));
        run_cycle(1'b0, 23'h000007, 6'h01, 2'b00, 16'hC0DE, 1, 16'h0000, 0);
        e = exp_q.pop_front(); o = obs_q.pop_front();
        n_checks++;
        if (o !== e) $display("FAIL post_reset_txn got %h want %h", o, e);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        txn_t e, o;
        exp_q.push_back(mk(1'b1, 32'h00000010, 2'b11, 16'h1111, 16'h0, 1, 1, 0, 3));
        exp_q.push_back(mk(1'b0, 32'h00000012, 2'b01, 16'h2222, 16'h3C3C, 2, 1, 3, 3));
        run_cycle(1'b0, 23'h000008, 6'h00, 2'b00, 16'h1111, 1, 16'h0000, 0);
        run_cycle(1'b1, 23'h000009, 6'h00, 2'b10, 16'h2222, 2, 16'h3C3C, 0);
        for (int k = 0; k < 2; k++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o !== e) $display("FAIL back_to_back_%0d got %h want %h", k, o, e);
            else n_pass++;
        end
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        rst = 1'b1;
        bus.epb_cs_n = 1'b1; bus.epb_oe_n = 1'b1; bus.epb_r_w_n = 1'b1; bus.epb_be_n = 2'b11;
        bus.epb_addr = '0; bus.epb_addr_gp = '0; bus.epb_data_in = '0;
        bus.wb_dat_i = '0; bus.wb_ack_i = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_ack_vs_timeout();
        test_abort();
        test_reset_mid_wb();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
